pipe_ctrl_seq: RTL

//  Parametrised pipeline stall/flush controller for the OpenMIPS core. Takes per-stage

---
 rtl/pipe_ctrl_seq_if.sv | 26 ++
 rtl/pipe_ctrl_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_seq_if.sv
// Stall/flush controller bus: stage stall requests and exception inputs in,
// stall vector, flush/redirect and debug counters out.
interface pipe_ctrl_seq_if #(
  parameter int unsigned NSTAGES = 6,
  parameter int unsigned CNT_W   = 32
) ();
  logic [NSTAGES-2:0] stallreq_i;
  logic [31:0]        excepttype_i;
  logic [31:0]        cp0_epc_i;
  logic [31:0]        ebase_i;
  logic [NSTAGES-1:0] stall_o;
  logic               flush_o;
  logic [31:0]        new_pc_o;
  logic               stall_timeout_o;
  logic [CNT_W-1:0]   stall_cycles_o;

  modport master (
    output stallreq_i, excepttype_i, cp0_epc_i, ebase_i,
    input  stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cycles_o
  );

  modport slave (
    input  stallreq_i, excepttype_i, cp0_epc_i, ebase_i,
    output stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl_seq.sv
// Pipeline stall/flush controller: priority stall vector, exception flush
// sequencer with redirect PC, stall watchdog and saturating stall-cycle counter.
module pipe_ctrl_seq #(
  parameter int unsigned NSTAGES    = 6,
  parameter int unsigned FLUSH_CYC  = 1,
  parameter logic [31:0] INT_OFF    = 32'h20,
  parameter logic [31:0] EXC_OFF    = 32'h40,
  parameter int unsigned WDOG_W     = 10,
  parameter int unsigned WDOG_LIMIT = 1000,
  parameter int unsigned CNT_W      = 32
) (
  input logic            clk,
  input logic            rst,
  pipe_ctrl_seq_if.slave bus
);

  typedef enum logic [0:0] {ST_IDLE, ST_FLUSH} state_t;

  localparam int unsigned     FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYC - 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM_V = WDOG_W'(WDOG_LIMIT);

  state_t             r_state;
  logic [FC_W-1:0]    r_cnt;
  logic               r_flush;
  logic [31:0]        r_new_pc;
  logic [WDOG_W-1:0]  r_wdog;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_stall_cycles;

  logic [NSTAGES-1:0] w_stall;
  logic               w_any;
  logic               w_stalling;
  logic               w_exc;
  logic [31:0]        w_exc_pc;
  logic [WDOG_W-1:0]  w_wdog_inc;

  assign w_exc = (bus.excepttype_i != '0);

  // Stall vector: bit k set when any request at stage k-1 or younger is
  // raised, which equals (1<<(j+2))-1 for the highest requesting stage j.
  always_comb begin
    w_stall = '0;
    w_any   = 1'b0;
    for (int unsigned i = 0; i < NSTAGES - 1; i++) begin
      w_any = w_any | bus.stallreq_i[NSTAGES-2-i];
      w_stall[NSTAGES-1-i] = w_any;
    end
    w_stall[0] = w_any;
    if (rst || w_exc || (r_state == ST_FLUSH)) begin
      w_stall = '0;
    end
  end

  assign w_stalling = (w_stall != '0);

  // Redirect target for the exception currently presented by MEM.
  always_comb begin
    w_exc_pc = bus.ebase_i + EXC_OFF;
    case (bus.excepttype_i)
      32'h1:                       w_exc_pc = bus.ebase_i + INT_OFF;
      32'h8, 32'ha, 32'hc, 32'hd:  w_exc_pc = bus.ebase_i + EXC_OFF;
      32'he:                       w_exc_pc = bus.cp0_epc_i;
      default:                     w_exc_pc = bus.ebase_i + EXC_OFF;
    endcase
  end

  // Flush sequencer: accept an exception only in IDLE, then hold flush for FLUSH_CYC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_flush  <= 1'b0;
      r_new_pc <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_exc) begin
            r_state  <= ST_FLUSH;
            r_flush  <= 1'b1;
            r_new_pc <= w_exc_pc;
            r_cnt    <= FC_INIT;
          end
        end
        ST_FLUSH: begin
          if (r_cnt == '0) begin
            r_state  <= ST_IDLE;
            r_flush  <= 1'b0;
            r_new_pc <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_flush  <= 1'b0;
          r_new_pc <= '0;
        end
      endcase
    end
  end

  assign w_wdog_inc = (r_wdog == '1) ? r_wdog : r_wdog + WDOG_W'(1);

  // Watchdog: counts consecutive stalled cycles, sticky timeout when the limit is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (!w_stalling || r_flush) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= w_wdog_inc;
      if (w_wdog_inc == WDOG_LIM_V) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Saturating count of all stalled cycles, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stalling && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign bus.stall_o         = w_stall;
  assign bus.flush_o         = r_flush;
  assign bus.new_pc_o        = r_new_pc;
  assign bus.stall_timeout_o = r_timeout;
  assign bus.stall_cycles_o  = r_stall_cycles;

endmodule
